// File: rtl/dot_prod_feeder.sv
// dot_prod_feeder: streams x samples against a stored reference frame, emitting aligned x/y pairs.
// Optional DOT_PROD_FEEDER_CONJ_Y_EN: emit conjugated reference (yq negated, saturating). Rev 1.0
`default_nettype none

module dot_prod_feeder #(
  parameter int xi_bits             = 12,
  parameter int xq_bits             = 12,
  parameter int yi_bits             = 12,
  parameter int yq_bits             = 12,
  parameter int length              = 5,
  parameter int length_counter_bits = 3
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           ref_wr_en,
  input  logic [length_counter_bits-1:0] ref_wr_addr,
  input  logic [yi_bits-1:0]             ref_wr_i,
  input  logic [yq_bits-1:0]             ref_wr_q,
  input  logic                           start,
  output logic                           busy,
  output logic                           frame_done,
  input  logic                           m_axis_in_tvalid,
  input  logic [xi_bits-1:0]             in_i,
  input  logic [xq_bits-1:0]             in_q,
  output logic                           s_axis_in_tready,
  input  logic                           m_axis_product_tready,
  output logic                           s_axis_x_tvalid,
  output logic [xi_bits-1:0]             xi,
  output logic [xq_bits-1:0]             xq,
  output logic                           s_axis_y_tvalid,
  output logic [yi_bits-1:0]             yi,
  output logic [yq_bits-1:0]             yq
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_STREAM = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  localparam logic [length_counter_bits-1:0] c_last   = length_counter_bits'(length - 1);
  localparam logic [yq_bits-1:0]             c_yq_min = {1'b1, {(yq_bits-1){1'b0}}};
  localparam logic [yq_bits-1:0]             c_yq_max = {1'b0, {(yq_bits-1){1'b1}}};

  state_t                         r_state;
  logic [length_counter_bits-1:0] r_cnt;
  logic                           r_valid;
  logic                           r_busy;
  logic                           r_frame_done;
  logic [xi_bits-1:0]             r_xi;
  logic [xq_bits-1:0]             r_xq;
  logic [yi_bits-1:0]             r_yi;
  logic [yq_bits-1:0]             r_yq;

  logic [yi_bits-1:0] r_ref_i [length];
  logic [yq_bits-1:0] r_ref_q [length];

  logic               w_tready;
  logic               w_accept;
  logic               w_xfer;
  logic [yi_bits-1:0] w_yi;
  logic [yq_bits-1:0] w_yq_raw;
  logic [yq_bits-1:0] w_yq;

  assign w_tready = (r_state == S_STREAM) && (!r_valid || m_axis_product_tready);
  assign w_accept = m_axis_in_tvalid && w_tready;
  assign w_xfer   = r_valid && m_axis_product_tready;
  assign w_yi     = r_ref_i[r_cnt];
  assign w_yq_raw = r_ref_q[r_cnt];

  always_comb begin
    w_yq = w_yq_raw;
`ifdef DOT_PROD_FEEDER_CONJ_Y_EN
    // The most negative value has no positive twin, so it saturates.
    if (w_yq_raw == c_yq_min) begin
      w_yq = c_yq_max;
    end else begin
      w_yq = -w_yq_raw;
    end
`endif
  end

  // Reference storage has no reset so contents survive rst.
  always_ff @(posedge clk) begin
    if (r_state == S_IDLE && ref_wr_en && ref_wr_addr <= c_last) begin
      r_ref_i[ref_wr_addr] <= ref_wr_i;
      r_ref_q[ref_wr_addr] <= ref_wr_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_valid      <= 1'b0;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
      r_xi         <= '0;
      r_xq         <= '0;
      r_yi         <= '0;
      r_yq         <= '0;
    end else begin
      r_frame_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state <= S_STREAM;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
          end
        end
        S_STREAM: begin
          if (w_accept) begin
            r_xi    <= in_i;
            r_xq    <= in_q;
            r_yi    <= w_yi;
            r_yq    <= w_yq;
            r_valid <= 1'b1;
            if (r_cnt == c_last) begin
              r_state <= S_DONE;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end else if (w_xfer) begin
            r_valid <= 1'b0;
          end
        end
        S_DONE: begin
          // Finish only once the final pair has left or is leaving now.
          if (!r_valid || w_xfer) begin
            r_valid      <= 1'b0;
            r_frame_done <= 1'b1;
            r_busy       <= 1'b0;
            r_state      <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign s_axis_in_tready = w_tready;
  assign s_axis_x_tvalid  = r_valid;
  assign s_axis_y_tvalid  = r_valid;
  assign xi               = r_xi;
  assign xq               = r_xq;
  assign yi               = r_yi;
  assign yq               = r_yq;
  assign busy             = r_busy;
  assign frame_done       = r_frame_done;

endmodule

`default_nettype wire

// File: tb/tb_dot_prod_feeder.sv
// tb_dot_prod_feeder: directed self-checking bench for dot_prod_feeder.
`default_nettype none

module tb_dot_prod_feeder;

  logic        clk = 1'b0;
  logic        rst;
  logic        ref_wr_en;
  logic [2:0]  ref_wr_addr;
  logic [11:0] ref_wr_i, ref_wr_q;
  logic        start;
  logic        busy, frame_done;
  logic        m_axis_in_tvalid;
  logic [11:0] in_i, in_q;
  logic        s_axis_in_tready;
  logic        m_axis_product_tready;
  logic        s_axis_x_tvalid, s_axis_y_tvalid;
  logic [11:0] xi, xq, yi, yq;

  int n_cmp = 0;
  int n_bad = 0;
  int fd_cnt = 0;
  logic [47:0] cap [$];

  dot_prod_feeder dut (
    .clk(clk), .rst(rst),
    .ref_wr_en(ref_wr_en), .ref_wr_addr(ref_wr_addr), .ref_wr_i(ref_wr_i), .ref_wr_q(ref_wr_q),
    .start(start), .busy(busy), .frame_done(frame_done),
    .m_axis_in_tvalid(m_axis_in_tvalid), .in_i(in_i), .in_q(in_q),
    .s_axis_in_tready(s_axis_in_tready),
    .m_axis_product_tready(m_axis_product_tready),
    .s_axis_x_tvalid(s_axis_x_tvalid), .xi(xi), .xq(xq),
    .s_axis_y_tvalid(s_axis_y_tvalid), .yi(yi), .yq(yq)
  );

  always #5 clk = ~clk;

  // Transfers and frame_done pulses observed mid-cycle.
  always @(negedge clk) begin
    if (s_axis_x_tvalid && m_axis_product_tready) cap.push_back({xi, xq, yi, yq});
    if (frame_done) fd_cnt++;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [11:0] exp_yq(input logic [11:0] q);
`ifdef DOT_PROD_FEEDER_CONJ_Y_EN
    return (q == 12'h800) ? 12'h7FF : 12'(-q);
`else
    return q;
`endif
  endfunction

  function automatic logic [47:0] exp_pair(input int k);
    return {12'(10 + k), 12'd0, 12'(2*k + 1), exp_yq(12'(2*k + 2))};
  endfunction

  task automatic write_ref(input logic [2:0] a, input logic [11:0] vi, input logic [11:0] vq);
    ref_wr_en = 1'b1; ref_wr_addr = a; ref_wr_i = vi; ref_wr_q = vq;
    @(posedge clk); #1;
    ref_wr_en = 1'b0;
  endtask

  task automatic begin_frame();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_after_start", busy, 1);
  endtask

  task automatic push_sample(input int k);
    bit acc = 0;
    int guard = 0;
    m_axis_in_tvalid = 1'b1; in_i = 12'(10 + k); in_q = 12'd0;
    while (!acc && guard < 20) begin
      @(negedge clk); acc = s_axis_in_tready;
      @(posedge clk); #1; guard++;
    end
    m_axis_in_tvalid = 1'b0;
    if (!acc) chk("accept_timeout", 0, 1);
    chk("lat_valids", {s_axis_x_tvalid, s_axis_y_tvalid}, 2'b11);
    chk("lat_pair", {xi, xq, yi, yq}, exp_pair(k));
  endtask

  task automatic run_frame(input bit stall, input bit wr_in_stream);
    int guard = 0;
    int fd0 = fd_cnt;
    cap.delete();
    begin_frame();
    for (int k = 0; k < 5; k++) begin
      if (wr_in_stream && k == 1) begin
        ref_wr_en = 1'b1; ref_wr_addr = 3'd0; ref_wr_i = 12'hFFF; ref_wr_q = 12'hFFF;
      end
      push_sample(k);
      ref_wr_en = 1'b0;
      if (stall && k == 2) begin
        m_axis_product_tready = 1'b0;
        m_axis_in_tvalid = 1'b1; in_i = 12'd13; in_q = 12'd0;
        repeat (3) begin
          @(negedge clk);
          chk("stall_tready", s_axis_in_tready, 0);
          chk("stall_valid", s_axis_x_tvalid, 1);
          chk("stall_hold", {xi, xq, yi, yq}, exp_pair(2));
          @(posedge clk); #1;
        end
        m_axis_product_tready = 1'b1;
      end
    end
    while (busy && guard < 10) begin
      @(posedge clk); #1; guard++;
    end
    chk("busy_low_after_frame", busy, 0);
    @(posedge clk); #1;
    chk("frame_done_once", fd_cnt - fd0, 1);
    chk("pair_count", cap.size(), 5);
    for (int k = 0; k < 5 && k < cap.size(); k++) chk($sformatf("pair%0d", k), cap[k], exp_pair(k));
  endtask

  initial begin
    int fd0;
    rst = 1'b1; ref_wr_en = 1'b0; ref_wr_addr = '0; ref_wr_i = '0; ref_wr_q = '0;
    start = 1'b0; m_axis_in_tvalid = 1'b0; in_i = '0; in_q = '0; m_axis_product_tready = 1'b1;
    #3;
    chk("rst_outputs", {busy, frame_done, s_axis_in_tready, s_axis_x_tvalid, s_axis_y_tvalid, xi, xq, yi, yq}, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    for (int k = 0; k < 5; k++) write_ref(3'(k), 12'(2*k + 1), 12'(2*k + 2));

    // Basic frame, then a mid-frame backpressure stall.
    run_frame(0, 0);
    run_frame(1, 0);

    // Out-of-range write and a write during streaming must both be ignored.
    write_ref(3'd6, 12'hFFF, 12'hFFF);
    run_frame(0, 1);
    run_frame(0, 0);

    // Reset after two accepts abandons the frame.
    fd0 = fd_cnt;
    begin_frame();
    push_sample(0);
    push_sample(1);
    rst = 1'b1;
    #1;
    chk("midrst_outputs", {busy, frame_done, s_axis_in_tready, s_axis_x_tvalid, s_axis_y_tvalid, xi, xq, yi, yq}, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("midrst_no_done", fd_cnt - fd0, 0);
    chk("midrst_idle", busy, 0);
    run_frame(0, 0);

`ifdef DOT_PROD_FEEDER_CONJ_Y_EN
    write_ref(3'd0, 12'd1, 12'h800);
    write_ref(3'd1, 12'd3, 12'd4);
    cap.delete();
    begin_frame();
    for (int k = 0; k < 5; k++) push_sample(k);
    repeat (4) @(posedge clk);
    #1;
    chk("conj_min", (cap.size() > 0) ? cap[0][11:0] : 12'h0, 12'h7FF);
    chk("conj_pos", (cap.size() > 1) ? cap[1][11:0] : 12'h0, 12'hFFC);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire

// File: doc/dot_prod_feeder.md
DOT_PROD_FEEDER -- requirements
Module: dot_prod_feeder

Interface
REQ-001 SHALL have parameter xi_bits, default 12: width of streamed x in-phase sample.
REQ-002 SHALL have parameter xq_bits, default 12: width of streamed x quadrature sample.
REQ-003 SHALL have parameter yi_bits, default 12: width of stored reference in-phase sample.
REQ-004 SHALL have parameter yq_bits, default 12: width of stored reference quadrature sample.
REQ-005 SHALL have parameter length, default 5: samples per frame and reference depth.
REQ-006 SHALL have parameter length_counter_bits, default 3: address/counter width; 2**length_counter_bits >= length.
REQ-007 SHALL have one clock and an asynchronous, active-high reset; ports: clk  in  1  sole clock, rising edge; rst  in  1  reset.
REQ-008 SHALL have ports: ref_wr_en  in  1  reference write strobe; ref_wr_addr  in  length_counter_bits  write index; ref_wr_i  in  yi_bits; ref_wr_q  in  yq_bits.
REQ-009 SHALL have ports: start  in  1  frame start pulse; busy  out  1  high outside IDLE; frame_done  out  1  one-cycle end-of-frame pulse.
REQ-010 SHALL have ports: m_axis_in_tvalid  in  1; in_i  in  xi_bits; in_q  in  xq_bits; s_axis_in_tready  out  1  input accept.
REQ-011 SHALL have ports: m_axis_product_tready  in  1  downstream ready; s_axis_x_tvalid  out  1; xi  out  xi_bits; xq  out  xq_bits; s_axis_y_tvalid  out  1; yi  out  yi_bits; yq  out  yq_bits.

Function
REQ-012 SHALL implement states IDLE, STREAM, DONE; rst forces IDLE.
REQ-013 SHALL, in IDLE with ref_wr_en high and ref_wr_addr < length, write ref_wr_i/ref_wr_q to reference entry ref_wr_addr on that edge; writes with ref_wr_addr >= length or outside IDLE SHALL be ignored.
REQ-014 SHALL move IDLE->STREAM on start high, clearing sample counter to 0; start in STREAM/DONE SHALL be ignored; start and ref_wr_en in the same IDLE cycle SHALL perform both.
REQ-015 SHALL drive s_axis_in_tready = (state==STREAM) && (!s_axis_x_tvalid || m_axis_product_tready), combinationally.
REQ-016 SHALL, on accept (m_axis_in_tvalid && s_axis_in_tready), register xi/xq <= in_i/in_q, yi/yq <= reference[counter], set both output valids, increment counter; latency accept-to-valid exactly 1 cycle.
REQ-017 SHALL keep s_axis_x_tvalid and s_axis_y_tvalid identical every cycle.
REQ-018 SHALL hold output data and valids stable while valid && !m_axis_product_tready.
REQ-019 SHALL clear valids when a transfer (valid && m_axis_product_tready) occurs without a same-cycle accept; simultaneous transfer and accept SHALL load the new pair with valids held high (no bubble).
REQ-020 SHALL move STREAM->DONE on accept with counter == length-1; counter SHALL not wrap within a frame.
REQ-021 SHALL, in DONE, deassert s_axis_in_tready, wait until output is empty or transferring, then pulse frame_done for one cycle and return to IDLE.
REQ-022 SHALL drive busy high in STREAM and DONE, low in IDLE.

Reset
REQ-023 SHALL asynchronously on rst: state IDLE, counter 0, all valids 0, xi/xq/yi/yq 0, busy 0, frame_done 0, s_axis_in_tready 0.
REQ-024 SHALL leave reference contents unchanged by rst; rst mid-frame SHALL abandon the frame with no frame_done.

Configuration
REQ-025 SHALL, with macro DOT_PROD_FEEDER_CONJ_Y_EN defined, emit yq as two's-complement negation of stored q (stored minimum value emits maximum positive value), yi unchanged.
REQ-026 SHALL, without DOT_PROD_FEEDER_CONJ_Y_EN, emit stored yi/yq unchanged.

Verification
REQ-027 Load ref[0..4]=(1,2),(3,4),(5,6),(7,8),(9,10), start, stream x=(10,0)..(14,0) with ready=1 -> pairs (10,0)/(1,2)...(14,0)/(9,10) one cycle after each accept, frame_done pulse once, busy low after.
REQ-028 Same frame with m_axis_product_tready low for 3 cycles mid-frame -> output held stable, s_axis_in_tready low, no sample lost or duplicated.
REQ-029 Write ref_wr_addr=6 value (-1,-1) and write during STREAM -> reference unchanged, frame output matches REQ-027.
REQ-030 rst asserted after 2 accepts -> all outputs 0 asynchronously, no frame_done; new frame after reset reproduces REQ-027 output.
REQ-031 With DOT_PROD_FEEDER_CONJ_Y_EN, ref q=-2048 and q=4 -> yq=2047 and yq=-4.
